// File: rtl/saper_pkg.sv
// Shared types and cell-addressing helpers for the minesweeper reveal engine.
package saper_pkg;

  localparam int unsigned DEF_MAX_DIM = 16;

  typedef enum logic [2:0] {
    StIdle,
    StPrecomp,
    StSeed,
    StSweep,
    StFinish
  } reveal_state_t;

  function automatic int cell_idx(input int x, input int y, input int stride);
    return y * stride + x;
  endfunction

  function automatic logic in_grid(input int x, input int y, input int n);
    return (x >= 0) && (y >= 0) && (x < n) && (y < n);
  endfunction

endpackage

// File: rtl/neighbour_count.sv
// Combinational count of set bitmap cells among the in-grid 8-neighbours of (x,y).
module neighbour_count
  import saper_pkg::*;
#(
  parameter int unsigned MAX_DIM = DEF_MAX_DIM,
  parameter int unsigned IDX_W   = $clog2(MAX_DIM)
) (
  input  logic [MAX_DIM*MAX_DIM-1:0] bitmap,
  input  logic [IDX_W-1:0]           x,
  input  logic [IDX_W-1:0]           y,
  input  logic [IDX_W:0]             n,
  output logic [3:0]                 count
);

  localparam int unsigned CELL_W = $clog2(MAX_DIM * MAX_DIM);

  always_comb begin
    count = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        // Edge masking: off-board neighbours never contribute, no wrap-around.
        if ((dx != 0 || dy != 0) && in_grid(int'(x) + dx, int'(y) + dy, int'(n))) begin
          if (bitmap[CELL_W'(cell_idx(int'(x) + dx, int'(y) + dy, MAX_DIM))]) begin
            count = count + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/reveal_engine.sv
// Minesweeper flood-reveal engine: precomputes a zero-neighbour map per game, then
// opens cells on request by repeated raster sweeps until a pass changes nothing.
module reveal_engine
  import saper_pkg::*;
#(
  parameter int unsigned MAX_DIM = DEF_MAX_DIM,
  parameter int unsigned IDX_W   = $clog2(MAX_DIM),
  parameter int unsigned CNT_W   = $clog2(MAX_DIM * MAX_DIM + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [IDX_W:0]             grid_dim,
  input  logic [MAX_DIM*MAX_DIM-1:0] mine_arr,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IDX_W-1:0]           req_x,
  input  logic [IDX_W-1:0]           req_y,
  output logic [MAX_DIM*MAX_DIM-1:0] revealed_arr,
  output logic [CNT_W-1:0]           revealed_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       hit_mine
);

  localparam int unsigned CELLS  = MAX_DIM * MAX_DIM;
  localparam int unsigned CELL_W = $clog2(CELLS);

  reveal_state_t      state_q, state_d;
  logic [IDX_W:0]     n_q, n_d;
  logic               zmap_valid_q, zmap_valid_d;
  logic [CELLS-1:0]   zero_map_q, zero_map_d;
  logic [CELLS-1:0]   revealed_q, revealed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [IDX_W-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic               dirty_q, dirty_d;
  logic               done_q, done_d;
  logic               hit_q, hit_d;

  logic [CELLS-1:0]   nb_map;
  logic [3:0]         nb_cnt;
  logic [IDX_W:0]     n_last;
  logic               col_last, row_last;
  logic [CELL_W-1:0]  scan_idx, tgt_idx;
  logic               set_now;

  assign n_last   = n_q - (IDX_W + 1)'(1);
  assign col_last = ({1'b0, sx_q} == n_last);
  assign row_last = ({1'b0, sy_q} == n_last);
  assign scan_idx = CELL_W'(cell_idx(int'(sx_q), int'(sy_q), MAX_DIM));
  assign tgt_idx  = CELL_W'(cell_idx(int'(tx_q), int'(ty_q), MAX_DIM));

  // One neighbour counter serves both phases: mines while precomputing, open zero
  // cells while sweeping.
  assign nb_map = (state_q == StPrecomp) ? mine_arr : (revealed_q & zero_map_q);

  neighbour_count #(
    .MAX_DIM (MAX_DIM),
    .IDX_W   (IDX_W)
  ) u_neighbour_count (
    .bitmap (nb_map),
    .x      (sx_q),
    .y      (sy_q),
    .n      (n_q),
    .count  (nb_cnt)
  );

  assign set_now = ~revealed_q[scan_idx] & ~mine_arr[scan_idx] & (nb_cnt != 4'd0);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    zmap_valid_d = zmap_valid_q;
    zero_map_d   = zero_map_q;
    revealed_d   = revealed_q;
    cnt_d        = cnt_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    dirty_d      = dirty_q;
    done_d       = 1'b0;
    hit_d        = 1'b0;

    if (clear) begin
      revealed_d   = '0;
      cnt_d        = '0;
      n_d          = grid_dim;
      zmap_valid_d = 1'b0;
      sx_d         = '0;
      sy_d         = '0;
      dirty_d      = 1'b0;
      state_d      = StPrecomp;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            tx_d    = req_x;
            ty_d    = req_y;
            state_d = StSeed;
          end
        end
        StPrecomp: begin
          zero_map_d[scan_idx] = (nb_cnt == 4'd0);
          if (col_last && row_last) begin
            sx_d         = '0;
            sy_d         = '0;
            zmap_valid_d = 1'b1;
            state_d      = StIdle;
          end else if (col_last) begin
            sx_d = '0;
            sy_d = sy_q + IDX_W'(1);
          end else begin
            sx_d = sx_q + IDX_W'(1);
          end
        end
        StSeed: begin
          if (({1'b0, tx_q} >= n_q) || ({1'b0, ty_q} >= n_q) || revealed_q[tgt_idx]) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            revealed_d[tgt_idx] = 1'b1;
            cnt_d               = cnt_q + CNT_W'(1);
            if (mine_arr[tgt_idx]) begin
              hit_d   = 1'b1;
              state_d = StIdle;
            end else if (!zero_map_q[tgt_idx]) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              sx_d    = '0;
              sy_d    = '0;
              dirty_d = 1'b0;
              state_d = StSweep;
            end
          end
        end
        StSweep: begin
          if (set_now) begin
            revealed_d[scan_idx] = 1'b1;
            cnt_d                = cnt_q + CNT_W'(1);
            dirty_d              = 1'b1;
          end
          if (col_last && row_last) begin
            sx_d = '0;
            sy_d = '0;
            if (dirty_q || set_now) begin
              dirty_d = 1'b0;
            end else begin
              state_d = StFinish;
            end
          end else if (col_last) begin
            sx_d = '0;
            sy_d = sy_q + IDX_W'(1);
          end else begin
            sx_d = sx_q + IDX_W'(1);
          end
        end
        StFinish: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      n_q          <= '0;
      zmap_valid_q <= 1'b0;
      zero_map_q   <= '0;
      revealed_q   <= '0;
      cnt_q        <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      dirty_q      <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      zmap_valid_q <= zmap_valid_d;
      zero_map_q   <= zero_map_d;
      revealed_q   <= revealed_d;
      cnt_q        <= cnt_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      dirty_q      <= dirty_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
    end
  end

  assign req_ready    = (state_q == StIdle) && zmap_valid_q;
  assign busy         = (state_q != StIdle);
  assign revealed_arr = revealed_q;
  assign revealed_cnt = cnt_q;
  assign done         = done_q;
  assign hit_mine     = hit_q;

endmodule
